// File: rtl/blp_button_pkg.sv
// Shared types for the button event decoder: FSM state encodings and event indices.
// WAIT_SECOND/DBL_HELD exist only when BUTTON_EVENT_DCLICK_EN is defined.
package blp_button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESSED     = 3'd1,
        ST_LONG_HELD   = 3'd2
`ifdef BUTTON_EVENT_DCLICK_EN
        ,
        ST_WAIT_SECOND = 3'd3,
        ST_DBL_HELD    = 3'd4
`endif
    } state_e;

    // Bit positions of each event in the downstream menu event vector.
    localparam int unsigned EV_PRESS   = 0;
    localparam int unsigned EV_RELEASE = 1;
    localparam int unsigned EV_SINGLE  = 2;
    localparam int unsigned EV_LONG    = 3;
    localparam int unsigned EV_DOUBLE  = 4;
    localparam int unsigned EV_COUNT   = 5;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_edge.sv
// Edge detector on the debounced button level.
// rise/fall are combinational for the FSM; press/released are the registered pulses.
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic button_valid,
    output logic rise,
    output logic fall,
    output logic press,
    output logic released
);

    logic prev;

    assign rise = button_valid & ~prev;
    assign fall = ~button_valid & prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            prev     <= button_valid;
            press    <= rise;
            released <= fall;
        end
    end

endmodule

// File: rtl/button_event.sv
// Press-event decoder: press/release, single click, long press and double click pulses.
// Double click and the click window are built only with BUTTON_EVENT_DCLICK_EN.
module button_event
    import blp_button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned DCLICK_CYCLES = 12_500_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic button_valid,
    output logic press,
    output logic released,
    output logic single_click,
    output logic long_press,
    output logic double_click
);

    localparam int unsigned SAT_CYC = max_u(LONG_CYCLES, DCLICK_CYCLES) - 1;
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(SAT_CYC);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_DCLICK_EN
    localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLICK_CYCLES - 1);
`endif

    logic rise;
    logic fall;

    button_edge u_edge (
        .clk          (clk),
        .rst          (rst),
        .button_valid (button_valid),
        .rise         (rise),
        .fall         (fall),
        .press        (press),
        .released     (released)
    );

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             single_d;
    logic             long_d;
`ifdef BUTTON_EVENT_DCLICK_EN
    logic             double_d;
`endif

    // Saturate rather than wrap so a stuck state can never retrigger.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        single_d = 1'b0;
        long_d   = 1'b0;
`ifdef BUTTON_EVENT_DCLICK_EN
        double_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                cnt_d = cnt_inc;
                // A fall on the terminal-count edge still counts as short.
                if (fall) begin
                    cnt_d = '0;
`ifdef BUTTON_EVENT_DCLICK_EN
                    state_d = ST_WAIT_SECOND;
`else
                    state_d  = ST_IDLE;
                    single_d = 1'b1;
`endif
                end else if (cnt_q == LONG_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef BUTTON_EVENT_DCLICK_EN
            ST_WAIT_SECOND: begin
                cnt_d = cnt_inc;
                // A rise on the timeout edge still counts as a double click.
                if (rise) begin
                    cnt_d    = '0;
                    state_d  = ST_DBL_HELD;
                    double_d = 1'b1;
                end else if (cnt_q == DCLK_LAST) begin
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                    single_d = 1'b1;
                end
            end
            ST_DBL_HELD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            single_click <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            single_click <= single_d;
            long_press   <= long_d;
        end
    end

`ifdef BUTTON_EVENT_DCLICK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            double_click <= 1'b0;
        end else begin
            double_click <= double_d;
        end
    end
`else
    assign double_click = 1'b0;
`endif

endmodule
